// File: rtl/mprj_marker_profiler.sv
// Cycle-accurate latency profiler for the GPIO probe marker protocol.
// Each START..END window is timed into a small record buffer with a saturating total.
module mprj_marker_profiler #(
   parameter int                DATA_W     = 16,
   parameter int                TAG_W      = 8,
   parameter int                CNT_W      = 32,
   parameter int                NUM_RUNS   = 3,
   parameter logic [DATA_W-1:0] START_MARK = 16'h00A5,
   parameter logic [TAG_W-1:0]  END_MARK   = 8'h5A,
   parameter longint            TIMEOUT    = 250000,
   parameter int                IDX_W      = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1
) (
   input  logic                          clock,
   input  logic                          resetb,
   input  logic                          go,
   input  logic                          abort,
   input  logic [DATA_W-1:0]             probe_i,
   output logic                          busy,
   output logic                          run_done,
   output logic [$clog2(NUM_RUNS+1)-1:0] run_count,
   output logic                          all_done,
   output logic                          timeout,
   output logic [CNT_W-1:0]              total_cycles,
   input  logic [IDX_W-1:0]              rd_idx,
   output logic                          rd_valid,
   output logic [CNT_W-1:0]              rd_cycles,
   output logic [DATA_W-TAG_W-1:0]       rd_result
);

   localparam int             RC_W  = $clog2(NUM_RUNS+1);
   localparam int             RES_W = DATA_W - TAG_W;
   localparam logic [CNT_W:0] TO_V  = (CNT_W+1)'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

   state_t            state_q;
   logic              busy_q, run_done_q, all_done_q, timeout_q;
   logic [RC_W-1:0]   run_count_q;
   logic [CNT_W-1:0]  total_q, cnt_q;
   logic [CNT_W-1:0]  rec_cyc_q [NUM_RUNS];
   logic [RES_W-1:0]  rec_res_q [NUM_RUNS];
   logic [NUM_RUNS-1:0] rec_val_q;
   logic              rd_valid_q;
   logic [CNT_W-1:0]  rd_cyc_q;
   logic [RES_W-1:0]  rd_res_q;

   logic              end_hit, to_hit, wr_en, last_run;
   logic [CNT_W:0]    cnt_inc, tot_sum;
   logic [CNT_W-1:0]  wr_cycles;
   logic [RES_W-1:0]  wr_result;
   logic              rd_val_d;
   logic [CNT_W-1:0]  rd_cyc_d;
   logic [RES_W-1:0]  rd_res_d;

   always_comb begin
      cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
      end_hit   = (state_q == S_COUNT) && (probe_i[TAG_W-1:0] == END_MARK);
      to_hit    = (state_q == S_COUNT) && !end_hit && (cnt_inc == TO_V);
      wr_en     = !go && !abort && (end_hit || to_hit);
      last_run  = (run_count_q == RC_W'(NUM_RUNS-1));
      wr_cycles = end_hit ? cnt_inc[CNT_W-1:0] : TO_V[CNT_W-1:0];
      wr_result = end_hit ? probe_i[DATA_W-1:TAG_W] : '0;
      tot_sum   = {1'b0, total_q} + {1'b0, wr_cycles};
   end

   // Read mux forwards a record written this cycle; out-of-range indices fall through to zero.
   always_comb begin
      rd_val_d = 1'b0;
      rd_cyc_d = '0;
      rd_res_d = '0;
      for (int i = 0; i < NUM_RUNS; i++) begin
         if (int'(rd_idx) == i) begin
            if (wr_en && int'(run_count_q) == i) begin
               rd_val_d = 1'b1;
               rd_cyc_d = wr_cycles;
               rd_res_d = wr_result;
            end else begin
               rd_val_d = rec_val_q[i];
               rd_cyc_d = rec_cyc_q[i];
               rd_res_d = rec_res_q[i];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         run_done_q  <= 1'b0;
         all_done_q  <= 1'b0;
         timeout_q   <= 1'b0;
         run_count_q <= '0;
         total_q     <= '0;
         cnt_q       <= '0;
         rec_val_q   <= '0;
         for (int i = 0; i < NUM_RUNS; i++) begin
            rec_cyc_q[i] <= '0;
            rec_res_q[i] <= '0;
         end
         rd_valid_q  <= 1'b0;
         rd_cyc_q    <= '0;
         rd_res_q    <= '0;
      end else begin
         run_done_q <= 1'b0;
         if (go) begin
            state_q     <= S_ARM;
            busy_q      <= 1'b1;
            all_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            run_count_q <= '0;
            total_q     <= '0;
            cnt_q       <= '0;
            rec_val_q   <= '0;
            for (int i = 0; i < NUM_RUNS; i++) begin
               rec_cyc_q[i] <= '0;
               rec_res_q[i] <= '0;
            end
         end else if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_ARM: begin
                  if (probe_i == START_MARK) begin
                     state_q <= S_COUNT;
                     cnt_q   <= '0;
                  end
               end
               S_COUNT: begin
                  if (wr_en) begin
                     run_done_q  <= 1'b1;
                     run_count_q <= run_count_q + 1'b1;
                     total_q     <= tot_sum[CNT_W] ? '1 : tot_sum[CNT_W-1:0];
                     timeout_q   <= to_hit;
                     if (to_hit || last_run) begin
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        all_done_q <= 1'b1;
                     end else begin
                        state_q <= S_ARM;
                     end
                  end else begin
                     cnt_q <= cnt_inc[CNT_W-1:0];
                  end
               end
               default: ;
            endcase
            for (int i = 0; i < NUM_RUNS; i++) begin
               if (wr_en && int'(run_count_q) == i) begin
                  rec_cyc_q[i] <= wr_cycles;
                  rec_res_q[i] <= wr_result;
                  rec_val_q[i] <= 1'b1;
               end
            end
         end
         if (go) begin
            rd_valid_q <= 1'b0;
            rd_cyc_q   <= '0;
            rd_res_q   <= '0;
         end else begin
            rd_valid_q <= rd_val_d;
            rd_cyc_q   <= rd_cyc_d;
            rd_res_q   <= rd_res_d;
         end
      end
   end

   assign busy         = busy_q;
   assign run_done     = run_done_q;
   assign run_count    = run_count_q;
   assign all_done     = all_done_q;
   assign timeout      = timeout_q;
   assign total_cycles = total_q;
   assign rd_valid     = rd_valid_q;
   assign rd_cycles    = rd_cyc_q;
   assign rd_result    = rd_res_q;

endmodule

// File: tb/tb_mprj_marker_profiler.sv
// Randomized scoreboard bench for mprj_marker_profiler: a wide-counter instance (TIMEOUT=300)
// and a narrow one (CNT_W=8, TIMEOUT=250) checked against a run-level reference model.
module tb_mprj_marker_profiler;

   localparam logic [15:0] START = 16'h00A5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        go_s [2];
   logic        abort_s [2];
   logic [15:0] probe_s [2];
   logic [1:0]  rdi_s [2];

   logic        busy0, rdone0, adone0, to0, rval0;
   logic [1:0]  rc0;
   logic [31:0] tot0, rcyc0;
   logic [7:0]  rres0;
   logic        busy1, rdone1, adone1, to1, rval1;
   logic [1:0]  rc1;
   logic [7:0]  tot1, rcyc1;
   logic [7:0]  rres1;

   logic        busy_a [2], rdone_a [2], adone_a [2], to_a [2], rval_a [2];
   logic [1:0]  rc_a [2];
   logic [31:0] tot_a [2], rcyc_a [2];
   logic [7:0]  rres_a [2];

   assign busy_a[0] = busy0;  assign busy_a[1] = busy1;
   assign rdone_a[0] = rdone0; assign rdone_a[1] = rdone1;
   assign adone_a[0] = adone0; assign adone_a[1] = adone1;
   assign to_a[0] = to0;      assign to_a[1] = to1;
   assign rval_a[0] = rval0;  assign rval_a[1] = rval1;
   assign rc_a[0] = rc0;      assign rc_a[1] = rc1;
   assign tot_a[0] = tot0;    assign tot_a[1] = {24'd0, tot1};
   assign rcyc_a[0] = rcyc0;  assign rcyc_a[1] = {24'd0, rcyc1};
   assign rres_a[0] = rres0;  assign rres_a[1] = rres1;

   mprj_marker_profiler #(.TIMEOUT(300)) u_dut0 (
      .clock(clk), .resetb(rstn), .go(go_s[0]), .abort(abort_s[0]), .probe_i(probe_s[0]),
      .busy(busy0), .run_done(rdone0), .run_count(rc0), .all_done(adone0), .timeout(to0),
      .total_cycles(tot0), .rd_idx(rdi_s[0]), .rd_valid(rval0), .rd_cycles(rcyc0), .rd_result(rres0));

   mprj_marker_profiler #(.CNT_W(8), .TIMEOUT(250)) u_dut1 (
      .clock(clk), .resetb(rstn), .go(go_s[1]), .abort(abort_s[1]), .probe_i(probe_s[1]),
      .busy(busy1), .run_done(rdone1), .run_count(rc1), .all_done(adone1), .timeout(to1),
      .total_cycles(tot1), .rd_idx(rdi_s[1]), .rd_valid(rval1), .rd_cycles(rcyc1), .rd_result(rres1));

   typedef struct { longint tot; int rc; bit to; bit dn; } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   int     n_tot = 0;
   int     n_bad = 0;
   int     TO [2]   = '{300, 250};
   longint MAXT [2] = '{64'hFFFF_FFFF, 64'd255};

   int     m_rc [2];
   longint m_tot [2];
   bit     m_to [2], m_dn [2], m_busy [2];
   longint m_cyc [2][3];
   int     m_res [2][3];
   bit     m_val [2][3];

   function automatic void chk(string nm, int d, longint act, longint exp);
      n_tot++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
      end
   endfunction

   // Monitor: every run_done pulse must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         for (int d = 0; d < 2; d++) begin
            if (rdone_a[d]) begin
               if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                  chk("unexpected_run_done", d, 1, 0);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk("mon_total", d, tot_a[d], e.tot);
                  chk("mon_run_count", d, rc_a[d], e.rc);
                  chk("mon_timeout", d, to_a[d], e.to);
                  chk("mon_all_done", d, adone_a[d], e.dn);
                  chk("mon_busy", d, busy_a[d], !e.dn);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int d, input logic [15:0] v);
      probe_s[d] = v;
      @(posedge clk); #1;
   endtask

   function automatic logic [15:0] fill_arm();
      logic [15:0] v;
      do v = 16'($urandom); while (v == START);
      return v;
   endfunction

   function automatic logic [15:0] fill_cnt();
      logic [15:0] v;
      do v = 16'($urandom); while (v[7:0] == 8'h5A || v == START);
      return v;
   endfunction

   task automatic rec(input int d, input longint c, input int r, input bit to);
      exp_t e;
      m_cyc[d][m_rc[d]] = c;
      m_res[d][m_rc[d]] = r;
      m_val[d][m_rc[d]] = 1'b1;
      m_tot[d] = (m_tot[d] + c > MAXT[d]) ? MAXT[d] : m_tot[d] + c;
      m_rc[d]++;
      if (to) m_to[d] = 1'b1;
      if (to || m_rc[d] == 3) begin
         m_dn[d]   = 1'b1;
         m_busy[d] = 1'b0;
      end
      e.tot = m_tot[d]; e.rc = m_rc[d]; e.to = m_to[d]; e.dn = m_dn[d];
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // One window of L cycles ending with result r; L beyond TIMEOUT never sends END.
   task automatic do_run(input int d, input int L, input int r);
      logic [7:0] rb;
      rb = r[7:0];
      repeat ($urandom_range(0, 2)) step(d, fill_arm());
      step(d, START);
      if (L <= TO[d]) begin
         for (int i = 1; i < L; i++) step(d, fill_cnt());
         step(d, {rb, 8'h5A});
         rec(d, L, r, 1'b0);
      end else begin
         for (int i = 0; i < TO[d]; i++) step(d, fill_cnt());
         rec(d, TO[d], 0, 1'b1);
      end
   endtask

   task automatic chk_state(input int d);
      chk("run_count", d, rc_a[d], m_rc[d]);
      chk("total_cycles", d, tot_a[d], m_tot[d]);
      chk("all_done", d, adone_a[d], m_dn[d]);
      chk("timeout", d, to_a[d], m_to[d]);
      chk("busy", d, busy_a[d], m_busy[d]);
   endtask

   task automatic do_go(input int d);
      go_s[d] = 1'b1;
      @(posedge clk); #1;
      go_s[d] = 1'b0;
      m_rc[d] = 0; m_tot[d] = 0; m_to[d] = 0; m_dn[d] = 0; m_busy[d] = 1;
      for (int i = 0; i < 3; i++) begin
         m_val[d][i] = 0; m_cyc[d][i] = 0; m_res[d][i] = 0;
      end
      chk_state(d);
   endtask

   task automatic do_abort(input int d);
      abort_s[d] = 1'b1;
      @(posedge clk); #1;
      abort_s[d] = 1'b0;
      m_busy[d] = 0;
      chk_state(d);
   endtask

   task automatic rd_check(input int d);
      for (int i = 0; i < 4; i++) begin
         rdi_s[d] = i[1:0];
         @(posedge clk); #1;
         chk("rd_valid", d, rval_a[d], (i < 3) ? longint'(m_val[d][i]) : 0);
         chk("rd_cycles", d, rcyc_a[d], (i < 3) ? m_cyc[d][i] : 0);
         chk("rd_result", d, rres_a[d], (i < 3) ? longint'(m_res[d][i]) : 0);
      end
   endtask

   initial begin
      int L;
      rstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         go_s[d] = 1'b1; abort_s[d] = 1'b0; probe_s[d] = START; rdi_s[d] = 2'd0;
         m_rc[d] = 0; m_tot[d] = 0; m_to[d] = 0; m_dn[d] = 0; m_busy[d] = 0;
         for (int i = 0; i < 3; i++) begin
            m_val[d][i] = 0; m_cyc[d][i] = 0; m_res[d][i] = 0;
         end
      end

      // Reset held with go and START driven: everything stays zero.
      repeat (3) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, busy_a[d], 0);
            chk("rst_run_done", d, rdone_a[d], 0);
            chk("rst_rd_valid", d, rval_a[d], 0);
            chk("rst_rd_cycles", d, rcyc_a[d], 0);
            chk_state(d);
         end
      end
      rstn = 1'b1;
      for (int d = 0; d < 2; d++) begin
         go_s[d] = 1'b0; probe_s[d] = 16'h0000;
      end
      @(posedge clk); #1;
      chk_state(0);
      chk_state(1);

      // Three directed runs.
      do_go(0);
      do_run(0, 100, 8'h2A);
      do_run(0, 50, 8'h10);
      do_run(0, 200, 8'h7F);
      chk_state(0);
      rd_check(0);
      // Markers in DONE are ignored.
      step(0, START);
      step(0, 16'h335A);
      repeat (3) step(0, fill_cnt());
      chk_state(0);

      // Minimum window and run_done pulse width.
      do_go(0);
      do_run(0, 1, 8'h01);
      chk("run_done_high", 0, rdone_a[0], 1);
      step(0, 16'h0000);
      chk("run_done_low", 0, rdone_a[0], 0);
      do_run(0, $urandom_range(1, 60), $urandom_range(0, 255));
      do_run(0, $urandom_range(1, 60), $urandom_range(0, 255));
      chk_state(0);
      rd_check(0);

      // Timeout on the second run.
      do_go(0);
      do_run(0, 40, $urandom_range(0, 255));
      do_run(0, 400, 8'hEE);
      chk_state(0);
      rd_check(0);

      // Abort mid-count of run 1, then restart the session.
      do_go(0);
      do_run(0, 30, 8'h44);
      step(0, START);
      repeat (10) step(0, fill_cnt());
      do_abort(0);
      rd_check(0);
      probe_s[0] = 16'h0000;
      do_go(0);
      rd_check(0);
      do_run(0, 7, 8'h99);
      rd_check(0);
      chk_state(0);

      // Random sessions, lengths straddling TIMEOUT now and then.
      for (int s = 0; s < 4; s++) begin
         do_go(0);
         for (int r = 0; r < 3; r++) begin
            if (!m_dn[0]) begin
               L = ($urandom_range(0, 4) == 0) ? 298 + int'($urandom_range(0, 5)) : int'($urandom_range(1, 120));
               do_run(0, L, $urandom_range(0, 255));
            end
         end
         chk_state(0);
         rd_check(0);
      end

      // Narrow counter: saturating total.
      do_go(1);
      do_run(1, 200, 8'h12);
      do_run(1, 100, 8'h34);
      do_run(1, 10, 8'h56);
      chk_state(1);
      rd_check(1);

      // END exactly at TIMEOUT wins; next run times out.
      do_go(1);
      do_run(1, 250, 8'hA7);
      do_run(1, 260, 8'h00);
      chk_state(1);
      rd_check(1);

      repeat (2) @(posedge clk);
      #1;
      chk("pending_dut0", 0, q0.size(), 0);
      chk("pending_dut1", 1, q1.size(), 0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mprj_marker_profiler.md
# mprj_marker_profiler

Synthesizable latency profiler for the Caravel user-project GPIO marker protocol. Firmware drives a marker word onto the probe bus: a START code opens a measurement, an END tag in the low byte closes it, and the upper bits carry a result value. The block counts clock cycles for each start/end window, stores per-run cycle counts and results in a small record buffer, and keeps a running total. It sits next to the FIR user project and gives silicon the same measurement capability the simulation monitor provides, generalised to NUM_RUNS runs with configurable widths, marker codes and a timeout.

## Interface
- DATA_W, 16, probe width (mprj_io[31:16] slice)
- TAG_W, 8, width of low tag field; result field = probe[DATA_W-1:TAG_W]
- CNT_W, 32, cycle counter and total width
- NUM_RUNS, 3, runs per session (≥1)
- START_MARK, 16'h00A5, full-width start code (DATA_W bits)
- END_MARK, 8'h5A, tag-field end code (TAG_W bits)
- TIMEOUT, 250000, per-run cycle limit (≥1, < 2^CNT_W)
- IDX_W, max(1,$clog2(NUM_RUNS)), derived

- clock  in  1  single clock
- resetb  in  1  synchronous, active-low reset
- go  in  1  pulse: clear session, start arming run 0
- abort  in  1  pulse: return to IDLE, keep records
- probe_i  in  DATA_W  marker word
- busy  out  1  high in ARM or COUNT
- run_done  out  1  one-cycle pulse when a run record is written
- run_count  out  $clog2(NUM_RUNS+1)  records written this session
- all_done  out  1  level, session complete (normal or timeout)
- timeout  out  1  level, session ended by timeout
- total_cycles  out  CNT_W  saturating sum of recorded cycle counts
- rd_idx  in  IDX_W  record read index
- rd_valid  out  1  record rd_idx written this session
- rd_cycles  out  CNT_W  record cycle count
- rd_result  out  DATA_W-TAG_W  record result field

## Operation
- States: IDLE, ARM, COUNT, DONE. Reset → IDLE; all outputs and records 0.
- go (any state, priority over abort): clear run_count, total_cycles, all_done, timeout, all record valid bits; → ARM.
- abort (no go): → IDLE from any state; records, run_count, total retained; all_done unchanged.
- ARM: when probe_i == START_MARK (full width, level sensitive) → COUNT, cnt ← 0.
- COUNT, each edge: if probe_i[TAG_W-1:0] == END_MARK → write record[run_count] = {cycles = cnt+1, result = probe_i[DATA_W-1:TAG_W], valid=1}; total += cnt+1 (saturate at 2^CNT_W−1); run_count++; → DONE if run_count reaches NUM_RUNS else ARM.
- COUNT, not END: if cnt+1 == TIMEOUT → write record {cycles = TIMEOUT, result = 0, valid=1}, total += TIMEOUT, run_count++, timeout ← 1, → DONE; else cnt++.
- DONE: all_done = 1; ignore probe_i until go/abort.
- START code held after a run ends re-arms immediately (level sensitive); END is checked only in COUNT, so START_MARK whose tag equals END_MARK is a configuration error (not supported).
- Read port: rd_valid/rd_cycles/rd_result registered from rd_idx; rd_idx ≥ NUM_RUNS returns zeros.

## Timing
- Recorded cycles = rising edges after the start-detect edge up to and including the end-detect edge (start at edge k, end sampled at edge k+1 → 1).
- run_done, run_count, total_cycles, record, all_done, timeout update on the end/timeout edge; run_done high exactly one cycle after.
- ARM → COUNT on the same edge START is sampled; no idle cycle between consecutive runs.
- Read latency 1 cycle; a read of the record being written in the same cycle returns the new value next cycle.
- busy = (state == ARM || state == COUNT), registered with state.

## Test plan
- Reset: hold resetb=0 3 cycles with probe_i=16'h00A5, go=1 → all outputs 0, state IDLE after release.
- Three runs: go; probe 00A5, then 0x0000 for 99 cycles, then 0x2A5A → run 0 cycles=100, result=0x2A; repeat with 50/200 cycles, results 0x10/0x7F → all_done=1, run_count=3, total_cycles=350, rd over idx 0..2 matches.
- Minimum window: A5 one cycle then 0x015A → cycles=1, result=0x01, run_done pulse one cycle.
- Timeout: TIMEOUT=20, start then hold 0x0000 → record cycles=20, result=0, timeout=1, all_done=1, run_count=1.
- abort mid-COUNT of run 1 then go → run_count cleared to 0, rd_valid 0 for all, new session records from idx 0.
- Saturation: CNT_W=8, runs of 200 and 100 cycles → total_cycles=255, records 200 and 100.
